crack: RTL and testbench
========================

CRACK -- requirements
Module: crack

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous reset, active-high despite the name (reset when rst_n=1 at a rising clk edge).
REQ-003 SHALL have port enable, input, 1 bit: start request, sampled only while rdy=1.
REQ-004 SHALL have port rdy, output, 1 bit: high = idle and able to accept enable.
REQ-005 SHALL have port key, output, 24 bits: key found, or last key tried.
REQ-006 SHALL have port key_valid, output, 1 bit: high = key holds a key that decrypts the message to printable text.
REQ-007 SHALL have port ct_addr, output, 8 bits: read address into the external ciphertext memory (ct_mem, 256x8).
REQ-008 SHALL have port ct_rddata, input, 8 bits: ct_mem read data, valid exactly one clk after ct_addr is presented.

Function
REQ-009 SHALL treat ct_mem[0] as message length L (0..255) and ct_mem[1..L] as ciphertext bytes.
REQ-010 SHALL hold an internal 256x8 state array S (register array or inferred RAM) and a registered copy of L.
REQ-011 SHALL, on enable=1 while rdy=1, drop rdy the next cycle, clear key_valid, set candidate key to 24'h000000 and read L.
REQ-012 SHALL, per candidate key K, run ARC4 with key bytes k0=K[23:16], k1=K[15:8], k2=K[7:0] (keylength 3).
REQ-013 SHALL run INIT: S[i]=i for i=0..255.
REQ-014 SHALL run KSA: j=0; for i=0..255: j=(j+S[i]+k[i mod 3]) mod 256; swap S[i],S[j].
REQ-015 SHALL run PRGA: i=j=0; for n=1..L: i=i+1; j=j+S[i]; swap S[i],S[j]; pad=S[(S[i]+S[j]) mod 256]; p=pad XOR ct_mem[n]; all index arithmetic 8-bit wrap-around.
REQ-016 SHALL reject K as soon as any p lies outside 8'h20..8'h7E inclusive, abandoning the remaining PRGA bytes.
REQ-017 SHALL accept K when all L bytes are printable; L=0 accepts the first key tried (24'h000000).
REQ-018 SHALL, on rejection, increment K by 1 and restart at INIT; keys tried strictly ascending from 24'h000000.
REQ-019 SHALL, on acceptance, drive key=K, set key_valid=1, return to rdy=1.
REQ-020 SHALL, if 24'hFFFFFF is rejected, stop with key=24'hFFFFFF, key_valid=0, rdy=1 (no wrap to 0).
REQ-021 SHALL use states IDLE, READ_LEN, INIT, KSA, PRGA, CHECK, DONE; memory read/swap sub-steps may add states but every S read and ct read SHALL wait its one-cycle latency.
REQ-022 SHALL hold key and key_valid stable while rdy=1 until the next accepted enable.
REQ-023 SHALL ignore enable while rdy=0; enable held high for several cycles SHALL start exactly one search.
REQ-024 SHALL, when enable is still high as rdy returns to 1, start a new search (level-sensitive start).

Reset
REQ-025 SHALL, on reset, go to IDLE with rdy=1, key=24'h000000, key_valid=0, ct_addr=8'h00; S contents undefined.
REQ-026 SHALL let reset asserted mid-search abort it immediately, with outputs as REQ-025 on the following cycle.
REQ-027 SHALL give reset priority over enable in the same cycle.

Verification
REQ-028 SHALL be checked for: L=0, enable pulse -> rdy returns high, key=24'h000000, key_valid=1.
REQ-029 SHALL be checked for: ct_mem = "Hello" ARC4-encrypted with key 24'h000018 -> rdy high, key=24'h000018, key_valid=1, no smaller key printable-valid per a software model.
REQ-030 SHALL be checked for: ciphertext encrypted with key 24'h1E4600 (message from a software model) -> key=first printable key found by the model, key_valid=1.
REQ-031 SHALL be checked for: enable held 5 cycles -> exactly one search; rdy=0 throughout search; each ct_rddata used one cycle after its ct_addr.
REQ-032 SHALL be checked for: reset asserted during KSA -> next cycle rdy=1, key_valid=0, key=0; new enable restarts and finds the same key.
REQ-033 SHALL be checked for: L=1 with ct[1] chosen so no key yields a printable byte (model-verified), search from 24'hFFFFFE forced via a bench hook -> rdy=1, key=24'hFFFFFF, key_valid=0.

Source files
------------

// File: rtl/crack.sv
// ARC4 key search: sweeps 24-bit keys upward until the ciphertext decrypts to printable ASCII.
// S lives in a single-port RAM with registered read; ct_mem is external with one-cycle read latency.
module crack #(
  parameter logic [23:0] KEY_START = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        rdy,
  output logic [23:0] key,
  output logic        key_valid,
  output logic [7:0]  ct_addr,
  input  logic [7:0]  ct_rddata
);

  // state    | meaning
  // IDLE     | ready, waiting for enable
  // READ_LEN | ct_addr=0 presented
  // LEN_WAIT | capture L from ct_rddata
  // INIT     | S[i]=i, one entry per cycle
  // KSA      | read S[i]
  // KSA_SI   | latch S[i], new j, read S[j]
  // KSA_SJ   | write S[i]=S[j]
  // KSA_WJ   | write S[j]=old S[i], advance i
  // PRGA     | all bytes done -> CHECK, else i+1 and read S[i]
  // PRGA_SI  | latch S[i], new j, read S[j]
  // PRGA_SJ  | write S[i]=S[j]
  // PRGA_WJ  | write S[j]=old S[i], present ct address
  // PRGA_PAD | read S[S[i]+S[j]]
  // PRGA_CT  | pad xor ciphertext, reject on non-printable
  // CHECK    | accept, give up at last key, or try next key
  // DONE     | one cycle before returning to IDLE
  typedef enum logic [3:0] {
    IDLE, READ_LEN, LEN_WAIT, INIT, KSA, KSA_SI, KSA_SJ, KSA_WJ,
    PRGA, PRGA_SI, PRGA_SJ, PRGA_WJ, PRGA_PAD, PRGA_CT, CHECK, DONE
  } state_t;

  state_t      state, state_nx;
  logic [7:0]  s_mem [256];
  logic [7:0]  s_addr, s_wdata, s_rdata;
  logic        s_we;
  logic [23:0] key_q;
  logic        key_valid_q, fail_q;
  logic [7:0]  len_q, i_q, j_q, si_q, sj_q, n_q;
  logic [1:0]  ksel_q;
  logic [7:0]  kbyte, ksa_j, prga_j, plain;
  logic        printable;

  assign rdy       = (state == IDLE);
  assign key       = key_q;
  assign key_valid = key_valid_q;

  always_comb begin
    kbyte = key_q[7:0];
    case (ksel_q)
      2'd0:    kbyte = key_q[23:16];
      2'd1:    kbyte = key_q[15:8];
      default: kbyte = key_q[7:0];
    endcase
    ksa_j     = j_q + s_rdata + kbyte;
    prga_j    = j_q + s_rdata;
    plain     = s_rdata ^ ct_rddata;
    printable = (plain >= 8'h20) && (plain <= 8'h7e);
  end

  always_ff @(posedge clk) begin
    if (s_we) s_mem[s_addr] <= s_wdata;
    s_rdata <= s_mem[s_addr];
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_addr   = i_q;
    s_we     = 1'b0;
    s_wdata  = s_rdata;
    case (state)
      IDLE:     if (enable) state_nx = READ_LEN;
      READ_LEN: state_nx = LEN_WAIT;
      LEN_WAIT: state_nx = INIT;
      INIT: begin
        s_we    = 1'b1;
        s_wdata = i_q;
        if (i_q == 8'hff) state_nx = KSA;
      end
      KSA:      state_nx = KSA_SI;
      KSA_SI: begin
        s_addr   = ksa_j;
        state_nx = KSA_SJ;
      end
      KSA_SJ: begin
        s_we     = 1'b1;
        state_nx = KSA_WJ;
      end
      KSA_WJ: begin
        s_we     = 1'b1;
        s_addr   = j_q;
        s_wdata  = si_q;
        state_nx = (i_q == 8'hff) ? PRGA : KSA;
      end
      PRGA: begin
        if (n_q == len_q) begin
          state_nx = CHECK;
        end else begin
          s_addr   = i_q + 8'd1;
          state_nx = PRGA_SI;
        end
      end
      PRGA_SI: begin
        s_addr   = prga_j;
        state_nx = PRGA_SJ;
      end
      PRGA_SJ: begin
        s_we     = 1'b1;
        state_nx = PRGA_WJ;
      end
      PRGA_WJ: begin
        s_we     = 1'b1;
        s_addr   = j_q;
        s_wdata  = si_q;
        state_nx = PRGA_PAD;
      end
      PRGA_PAD: begin
        s_addr   = si_q + sj_q;
        state_nx = PRGA_CT;
      end
      PRGA_CT:  state_nx = printable ? PRGA : CHECK;
      CHECK:    state_nx = (!fail_q || key_q == 24'hffffff) ? DONE : INIT;
      DONE:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      key_q       <= 24'h000000;
      key_valid_q <= 1'b0;
      ct_addr     <= 8'h00;
      len_q       <= 8'h00;
      i_q         <= 8'h00;
      j_q         <= 8'h00;
      si_q        <= 8'h00;
      sj_q        <= 8'h00;
      n_q         <= 8'h00;
      ksel_q      <= 2'd0;
      fail_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            key_q       <= KEY_START;
            key_valid_q <= 1'b0;
            ct_addr     <= 8'h00;
          end
        end
        LEN_WAIT: begin
          len_q <= ct_rddata;
          i_q   <= 8'h00;
        end
        INIT: begin
          i_q <= i_q + 8'd1;
          if (i_q == 8'hff) begin
            j_q    <= 8'h00;
            ksel_q <= 2'd0;
          end
        end
        KSA_SI: begin
          si_q <= s_rdata;
          j_q  <= ksa_j;
        end
        KSA_WJ: begin
          i_q    <= i_q + 8'd1;
          ksel_q <= (ksel_q == 2'd2) ? 2'd0 : ksel_q + 2'd1;
          // i wraps to 0 here, which is exactly the PRGA starting index
          if (i_q == 8'hff) begin
            j_q    <= 8'h00;
            n_q    <= 8'h00;
            fail_q <= 1'b0;
          end
        end
        PRGA:     if (n_q != len_q) i_q <= i_q + 8'd1;
        PRGA_SI: begin
          si_q <= s_rdata;
          j_q  <= prga_j;
        end
        PRGA_SJ:  sj_q <= s_rdata;
        PRGA_WJ:  ct_addr <= n_q + 8'd1;
        PRGA_CT: begin
          n_q <= n_q + 8'd1;
          if (!printable) fail_q <= 1'b1;
        end
        CHECK: begin
          i_q <= 8'h00;
          if (!fail_q)                   key_valid_q <= 1'b1;
          else if (key_q != 24'hffffff) key_q       <= key_q + 24'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crack.sv
// Scoreboard bench for crack: an ARC4 software model predicts the first printable key for each search.
module tb_crack;

  logic        clk = 1'b0;
  logic        rst_n, enable, rdy, key_valid;
  logic [23:0] key;
  logic [7:0]  ct_addr, ct_rddata;
  logic        enable_b, rdy_b, key_valid_b;
  logic [23:0] key_b;
  logic [7:0]  ct_addr_b, ct_rddata_b;

  logic [7:0]  ct_mem   [256];
  logic [7:0]  ct_mem_b [256];
  logic [7:0]  pad_buf  [256];

  typedef struct {
    logic [23:0] key;
    logic        valid;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int starts   = 0;
  logic prev_rdy = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ct_rddata   <= ct_mem[ct_addr];
    ct_rddata_b <= ct_mem_b[ct_addr_b];
  end

  always @(negedge clk) begin
    if (prev_rdy && !rdy) starts++;
    prev_rdy = rdy;
  end

  crack dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rdy(rdy), .key(key),
    .key_valid(key_valid), .ct_addr(ct_addr), .ct_rddata(ct_rddata)
  );

  // second instance starts near the top of the key space
  crack #(.KEY_START(24'hfffffe)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .rdy(rdy_b), .key(key_b),
    .key_valid(key_valid_b), .ct_addr(ct_addr_b), .ct_rddata(ct_rddata_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit is_print(input logic [7:0] p);
    return (p >= 8'h20) && (p <= 8'h7e);
  endfunction

  task automatic gen_pad(input logic [23:0] k, input int n);
    int s[256];
    int i, j, t, kb;
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      if (a % 3 == 0)      kb = int'(k[23:16]);
      else if (a % 3 == 1) kb = int'(k[15:8]);
      else                 kb = int'(k[7:0]);
      j = (j + s[a] + kb) % 256;
      t = s[a]; s[a] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
    for (int b = 1; b <= n; b++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      pad_buf[b] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic model_search(input logic [23:0] start, output logic [23:0] found, output logic ok);
    logic [23:0] k;
    bit good;
    int len;
    k     = start;
    ok    = 1'b0;
    found = start;
    len   = int'(ct_mem[0]);
    for (int c = 0; c < 4096; c++) begin
      good = 1'b1;
      gen_pad(k, len);
      for (int b = 1; b <= len; b++) begin
        if (!is_print(pad_buf[b] ^ ct_mem[b])) begin
          good = 1'b0;
          break;
        end
      end
      found = k;
      if (good) begin
        ok = 1'b1;
        return;
      end
      if (k == 24'hffffff) return;
      k++;
    end
  endtask

  task automatic wait_rdy(input string tag, input bit use_b, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 45000; c++) begin
      @(negedge clk);
      if ((use_b ? rdy_b : rdy) == 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_val({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic pop_compare(input string tag, input logic [23:0] got_key, input logic got_valid);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_val({tag, "_key"}, 32'(got_key), 32'(e.key));
    check_val({tag, "_valid"}, 32'(got_valid), 32'(e.valid));
  endtask

  task automatic run_search(input string tag, input logic [23:0] ek, input logic ev);
    exp_t e;
    bit ok;
    e.key   = ek;
    e.valid = ev;
    exp_q.push_back(e);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    check_val({tag, "_rdy_drop"}, 32'(rdy), 32'd0);
    wait_rdy(tag, 1'b0, ok);
    if (ok) pop_compare(tag, key, key_valid);
  endtask

  initial begin
    string       hello;
    string       hi;
    logic [23:0] ek;
    logic        eok;
    logic [7:0]  pa, pb, c1;
    exp_t        e;
    bit          ok;
    int          s0, low_cnt, key_moves;

    rst_n    = 1'b1;
    enable   = 1'b0;
    enable_b = 1'b0;
    for (int a = 0; a < 256; a++) begin
      ct_mem[a]   = 8'h00;
      ct_mem_b[a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_val("rst_rdy", 32'(rdy), 32'd1);
    check_val("rst_key", 32'(key), 32'd0);
    check_val("rst_valid", 32'(key_valid), 32'd0);
    check_val("rst_ct_addr", 32'(ct_addr), 32'd0);
    rst_n = 1'b0;

    // empty message: first key accepted
    run_search("len0", 24'h000000, 1'b1);

    // enable held for five cycles starts exactly one search
    s0 = starts;
    e.key = 24'h000000; e.valid = 1'b1; exp_q.push_back(e);
    @(negedge clk);
    enable  = 1'b1;
    low_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (!rdy) low_cnt++;
    end
    enable = 1'b0;
    check_val("held_rdy_low", 32'(low_cnt), 32'd5);
    wait_rdy("held", 1'b0, ok);
    if (ok) pop_compare("held", key, key_valid);
    low_cnt   = 0;
    key_moves = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rdy) low_cnt++;
      if (key !== 24'h000000 || key_valid !== 1'b1) key_moves++;
    end
    check_val("held_stay_idle", 32'(low_cnt), 32'd0);
    check_val("held_key_stable", 32'(key_moves), 32'd0);
    check_val("held_one_search", 32'(starts - s0), 32'd1);

    // "Hello" under key 0x000018
    hello = "Hello";
    gen_pad(24'h000018, 5);
    ct_mem[0] = 8'd5;
    for (int b = 1; b <= 5; b++) ct_mem[b] = pad_buf[b] ^ hello[b-1];
    model_search(24'h000000, ek, eok);
    if (ek != 24'h000018) $display("note: model finds printable key 0x%06h before 0x000018", ek);
    run_search("hello", ek, eok);

    // "Hi" under key 0x1E4600; the first printable key is far lower
    hi = "Hi";
    gen_pad(24'h1e4600, 2);
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
    ct_mem[0] = 8'd2;
    for (int b = 1; b <= 2; b++) ct_mem[b] = pad_buf[b] ^ hi[b-1];
    model_search(24'h000000, ek, eok);
    run_search("k1e4600", ek, eok);

    // reset lands inside the first key's KSA
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (400) @(negedge clk);
    check_val("ksa_busy", 32'(rdy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ksa_rst_rdy", 32'(rdy), 32'd1);
    check_val("ksa_rst_valid", 32'(key_valid), 32'd0);
    check_val("ksa_rst_key", 32'(key), 32'd0);
    rst_n = 1'b0;
    run_search("after_rst", ek, eok);

    // reset wins over enable in the same cycle
    @(negedge clk);
    s0     = starts;
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check_val("rst_prio_rdy", 32'(rdy), 32'd1);
    @(negedge clk);
    rst_n  = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check_val("rst_prio_nostart", 32'(starts - s0), 32'd0);

    // level-sensitive start: enable still high when rdy returns
    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
    s0 = starts;
    e.key = 24'h000000; e.valid = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back(e);
    @(negedge clk);
    enable = 1'b1;
    wait_rdy("level1", 1'b0, ok);
    if (ok) pop_compare("level1", key, key_valid);
    @(negedge clk);
    check_val("level_restart", 32'(rdy), 32'd0);
    enable = 1'b0;
    wait_rdy("level2", 1'b0, ok);
    if (ok) pop_compare("level2", key, key_valid);
    repeat (2) @(negedge clk);
    check_val("level_two_searches", 32'(starts - s0), 32'd2);

    // exhaust the key space from 0xFFFFFE with an unprintable single byte
    gen_pad(24'hfffffe, 1);
    pa = pad_buf[1];
    gen_pad(24'hffffff, 1);
    pb = pad_buf[1];
    c1 = 8'h00;
    for (int c = 0; c < 256; c++) begin
      if (!is_print(pa ^ 8'(c)) && !is_print(pb ^ 8'(c))) begin
        c1 = 8'(c);
        break;
      end
    end
    ct_mem_b[0] = 8'd1;
    ct_mem_b[1] = c1;
    e.key = 24'hffffff; e.valid = 1'b0; exp_q.push_back(e);
    @(negedge clk);
    enable_b = 1'b1;
    @(negedge clk);
    enable_b = 1'b0;
    check_val("top_rdy_drop", 32'(rdy_b), 32'd0);
    wait_rdy("top", 1'b1, ok);
    if (ok) pop_compare("top", key_b, key_valid_b);
    repeat (5) @(negedge clk);
    check_val("top_no_wrap_key", 32'(key_b), 32'h00ffffff);
    check_val("top_stay_idle", 32'(rdy_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
